// File: rtl/nv_nvdla_cvif_read_cq.sv
// CVIF read context queue: THREADS independent FIFOs of DEPTH x PD_W context
// words. Ingress pushes one word per issued read on its thread, and egress pops
// the head of a selected thread as read data returns. Threads never block each other.
`timescale 1ns/1ps
module nv_nvdla_cvif_read_cq #(
    parameter int THREADS = 10,
    parameter int DEPTH   = 8,
    parameter int PD_W    = 7
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                cq_wr_pvld,
    output logic                cq_wr_prdy,
    input  logic [3:0]          cq_wr_thread_id,
    input  logic [PD_W-1:0]     cq_wr_pd,
    output logic [THREADS-1:0]  cq_rd_pvld,
    input  logic [3:0]          cq_rd_thread_id,
    input  logic                cq_rd_pop,
    output logic [PD_W-1:0]     cq_rd_pd,
    output logic                cq_err
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [4:0]     NTHR     = 5'(THREADS);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

    logic                        wr_in_range;
    logic                        rd_in_range;
    logic                        wr_fire;
    logic                        pop_ok;
    logic [THREADS-1:0]          full_vec;
    logic [THREADS-1:0]          empty_vec;
    logic [THREADS-1:0]          wr_en;
    logic [THREADS-1:0]          pop_en;
    logic [THREADS-1:0]          nonempty_next;
    logic [THREADS-1:0][PD_W-1:0] head;
    logic [THREADS-1:0]          rd_pvld_reg;
    logic                        err_reg;
    logic                        err_next;

    assign wr_in_range = ({1'b0, cq_wr_thread_id} < NTHR);
    assign rd_in_range = ({1'b0, cq_rd_thread_id} < NTHR);

    // Acceptance only looks at the current count: a same-cycle pop never frees a full thread.
    assign cq_wr_prdy = wr_in_range & ~full_vec[cq_wr_thread_id];
    assign wr_fire    = cq_wr_pvld & cq_wr_prdy;
    assign pop_ok     = cq_rd_pop & rd_in_range & ~empty_vec[cq_rd_thread_id];

    // Head of the selected thread, forced to zero when nothing valid is there.
    assign cq_rd_pd = (rd_in_range & ~empty_vec[cq_rd_thread_id]) ?
                      head[cq_rd_thread_id] : '0;

    // Illegal requests: a write to a non-existent thread, or a pop that cannot be honoured.
    assign err_next = err_reg | (cq_wr_pvld & ~wr_in_range) | (cq_rd_pop & ~pop_ok);

    assign cq_rd_pvld = rd_pvld_reg;
    assign cq_err     = err_reg;

    for (genvar gi = 0; gi < THREADS; gi++) begin : g_thread
        logic [PD_W-1:0] mem [DEPTH];
        logic [AW-1:0]   wr_ptr_reg;
        logic [AW-1:0]   rd_ptr_reg;
        logic [CW-1:0]   cnt_reg;
        logic [CW-1:0]   cnt_next;

        assign wr_en[gi]  = wr_fire & (cq_wr_thread_id == 4'(gi));
        assign pop_en[gi] = pop_ok  & (cq_rd_thread_id == 4'(gi));

        // Occupancy update; a simultaneous push and pop leaves the count unchanged.
        always_comb begin
            cnt_next = cnt_reg;
            if (wr_en[gi] && !pop_en[gi]) begin
                cnt_next = cnt_reg + CW'(1);
            end else if (!wr_en[gi] && pop_en[gi]) begin
                cnt_next = cnt_reg - CW'(1);
            end
        end

        // Pointer and count registers; pointers wrap naturally at DEPTH.
        always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                cnt_reg    <= '0;
            end else begin
                if (wr_en[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop_en[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                cnt_reg <= cnt_next;
            end
        end

        // Context storage; contents are don't-care until written, so no reset.
        always_ff @(posedge nvdla_core_clk) begin
            if (wr_en[gi]) begin
                mem[wr_ptr_reg] <= cq_wr_pd;
            end
        end

        assign head[gi]          = mem[rd_ptr_reg];
        assign full_vec[gi]      = (cnt_reg == CNT_FULL);
        assign empty_vec[gi]     = (cnt_reg == '0);
        assign nonempty_next[gi] = (cnt_next != '0);
    end

    // Registered per-thread valid and sticky error flag.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_pvld_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            rd_pvld_reg <= nonempty_next;
            err_reg     <= err_next;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cvif_read_cq.sv
// Directed bench for the CVIF read context queue: a vector table covering
// ordering, interleaving and same-cycle push/pop, plus hand sequences for
// full-thread back-pressure, pointer wrap, errors and asynchronous reset.
`timescale 1ns/1ps
module tb_nv_nvdla_cvif_read_cq;

    logic        clk;
    logic        rstn;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [3:0]  wr_tid;
    logic [6:0]  wr_pd;
    logic [9:0]  rd_pvld;
    logic [3:0]  rd_tid;
    logic        rd_pop;
    logic [6:0]  rd_pd;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       wv;
        logic [3:0] wt;
        logic [6:0] wd;
        logic [3:0] rs;
        logic       rp;
        logic       ep;
        logic [6:0] ed;
        logic [9:0] ev;
        logic       ee;
    } vec_t;

    vec_t vq[$];

    nv_nvdla_cvif_read_cq #(.THREADS(10), .DEPTH(8), .PD_W(7)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cq_wr_pvld      (wr_pvld),
        .cq_wr_prdy      (wr_prdy),
        .cq_wr_thread_id (wr_tid),
        .cq_wr_pd        (wr_pd),
        .cq_rd_pvld      (rd_pvld),
        .cq_rd_thread_id (rd_tid),
        .cq_rd_pop       (rd_pop),
        .cq_rd_pd        (rd_pd),
        .cq_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic wv, input logic [3:0] wt, input logic [6:0] wd,
                       input logic [3:0] rs, input logic rp);
        wr_pvld = wv;
        wr_tid  = wt;
        wr_pd   = wd;
        rd_tid  = rs;
        rd_pop  = rp;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic wv, input logic [3:0] wt, input logic [6:0] wd,
                       input logic [3:0] rs, input logic rp, input logic ep,
                       input logic [6:0] ed, input logic [9:0] ev, input logic ee);
        vec_t v;
        v.wv = wv; v.wt = wt; v.wd = wd; v.rs = rs; v.rp = rp;
        v.ep = ep; v.ed = ed; v.ev = ev; v.ee = ee;
        vq.push_back(v);
    endtask

    initial begin
        logic [6:0] exp_d;

        // Thread 3 in-order push then pop.
        add(1'b1, 4'd3, 7'h11, 4'd3, 1'b0, 1'b1, 7'h00, 10'h000, 1'b0);
        add(1'b1, 4'd3, 7'h22, 4'd3, 1'b0, 1'b1, 7'h11, 10'h008, 1'b0);
        add(1'b1, 4'd3, 7'h33, 4'd3, 1'b0, 1'b1, 7'h11, 10'h008, 1'b0);
        add(1'b0, 4'd3, 7'h00, 4'd3, 1'b1, 1'b1, 7'h11, 10'h008, 1'b0);
        add(1'b0, 4'd3, 7'h00, 4'd3, 1'b1, 1'b1, 7'h22, 10'h008, 1'b0);
        add(1'b0, 4'd3, 7'h00, 4'd3, 1'b1, 1'b1, 7'h33, 10'h008, 1'b0);
        add(1'b0, 4'd3, 7'h00, 4'd3, 1'b0, 1'b1, 7'h00, 10'h000, 1'b0);
        // Interleaved threads 0 and 9.
        add(1'b1, 4'd0, 7'h01, 4'd9, 1'b0, 1'b1, 7'h00, 10'h000, 1'b0);
        add(1'b1, 4'd9, 7'h02, 4'd9, 1'b0, 1'b1, 7'h00, 10'h001, 1'b0);
        add(1'b1, 4'd0, 7'h03, 4'd9, 1'b0, 1'b1, 7'h02, 10'h201, 1'b0);
        add(1'b1, 4'd9, 7'h04, 4'd9, 1'b0, 1'b1, 7'h02, 10'h201, 1'b0);
        add(1'b0, 4'd0, 7'h00, 4'd9, 1'b1, 1'b1, 7'h02, 10'h201, 1'b0);
        add(1'b0, 4'd0, 7'h00, 4'd9, 1'b1, 1'b1, 7'h04, 10'h201, 1'b0);
        add(1'b0, 4'd0, 7'h00, 4'd0, 1'b1, 1'b1, 7'h01, 10'h001, 1'b0);
        add(1'b0, 4'd0, 7'h00, 4'd0, 1'b1, 1'b1, 7'h03, 10'h001, 1'b0);
        add(1'b0, 4'd0, 7'h00, 4'd0, 1'b0, 1'b1, 7'h00, 10'h000, 1'b0);
        // Same-cycle push and pop on thread 2 holding one word.
        add(1'b1, 4'd2, 7'h0A, 4'd2, 1'b0, 1'b1, 7'h00, 10'h000, 1'b0);
        add(1'b1, 4'd2, 7'h55, 4'd2, 1'b1, 1'b1, 7'h0A, 10'h004, 1'b0);
        add(1'b0, 4'd2, 7'h00, 4'd2, 1'b0, 1'b1, 7'h55, 10'h004, 1'b0);
        add(1'b0, 4'd2, 7'h00, 4'd2, 1'b1, 1'b1, 7'h55, 10'h004, 1'b0);
        add(1'b0, 4'd2, 7'h00, 4'd2, 1'b0, 1'b1, 7'h00, 10'h000, 1'b0);

        rstn = 1'b0;
        drv(1'b0, 4'd0, 7'h00, 4'd0, 1'b0);
        #12;
        chk("reset_pvld", 32'(rd_pvld), 32'h0);
        chk("reset_err",  32'(err),     32'h0);
        chk("reset_rdpd", 32'(rd_pd),   32'h0);
        chk("reset_prdy", 32'(wr_prdy), 32'h1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        foreach (vq[i]) begin
            drv(vq[i].wv, vq[i].wt, vq[i].wd, vq[i].rs, vq[i].rp);
            #2;
            $display("vec %0d wv=%0d wt=%0d wd=%h rs=%0d rp=%0d -> prdy=%0d rd_pd=%h pvld=%h err=%0d",
                     i, vq[i].wv, vq[i].wt, vq[i].wd, vq[i].rs, vq[i].rp, wr_prdy, rd_pd, rd_pvld, err);
            chk($sformatf("vec%0d_prdy", i), 32'(wr_prdy), 32'(vq[i].ep));
            chk($sformatf("vec%0d_rdpd", i), 32'(rd_pd),   32'(vq[i].ed));
            chk($sformatf("vec%0d_pvld", i), 32'(rd_pvld), 32'(vq[i].ev));
            chk($sformatf("vec%0d_err",  i), 32'(err),     32'(vq[i].ee));
            cyc();
        end

        // Fill thread 5, check back-pressure is per thread and there is no full bypass.
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 4'd5, 7'(8'h40 + i), 4'd5, 1'b0);
            #2;
            chk($sformatf("fill5_prdy%0d", i), 32'(wr_prdy), 32'h1);
            cyc();
        end
        drv(1'b0, 4'd5, 7'h00, 4'd5, 1'b0);
        #2;
        chk("full5_prdy", 32'(wr_prdy), 32'h0);
        chk("full5_pvld", 32'(rd_pvld), 32'h020);
        wr_tid = 4'd6;
        #1;
        chk("id6_prdy", 32'(wr_prdy), 32'h1);
        wr_pvld = 1'b1;
        wr_pd   = 7'h7F;
        $display("write t6 7f prdy=%0d", wr_prdy);
        cyc();
        drv(1'b1, 4'd5, 7'h7F, 4'd5, 1'b1);
        #2;
        $display("full push+pop t5 prdy=%0d rd_pd=%h", wr_prdy, rd_pd);
        chk("nobypass_prdy", 32'(wr_prdy), 32'h0);
        chk("nobypass_rdpd", 32'(rd_pd),   32'h40);
        cyc();
        drv(1'b1, 4'd5, 7'h7F, 4'd5, 1'b0);
        #2;
        $display("held write t5 prdy=%0d", wr_prdy);
        chk("cnt7_prdy", 32'(wr_prdy), 32'h1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 7) ? 7'(8'h41 + i) : 7'h7F;
            drv(1'b0, 4'd5, 7'h00, 4'd5, 1'b1);
            #2;
            $display("pop t5 #%0d rd_pd=%h", i, rd_pd);
            chk($sformatf("drain5_%0d", i), 32'(rd_pd), 32'(exp_d));
            cyc();
        end
        drv(1'b0, 4'd6, 7'h00, 4'd6, 1'b1);
        #2;
        chk("pop6", 32'(rd_pd), 32'h7F);
        cyc();
        drv(1'b0, 4'd0, 7'h00, 4'd0, 1'b0);
        #2;
        chk("after_full_pvld", 32'(rd_pvld), 32'h0);
        chk("after_full_err",  32'(err),     32'h0);
        cyc();

        // Pointer wrap on thread 1 with alternating push/pop.
        for (int i = 0; i < 20; i++) begin
            exp_d = 7'(i * 5 + 3);
            drv(1'b1, 4'd1, exp_d, 4'd1, 1'b0);
            #2;
            chk($sformatf("wrap_prdy%0d", i), 32'(wr_prdy), 32'h1);
            cyc();
            drv(1'b0, 4'd1, 7'h00, 4'd1, 1'b1);
            #2;
            $display("wrap %0d pop rd_pd=%h", i, rd_pd);
            chk($sformatf("wrap_rdpd%0d", i), 32'(rd_pd),   32'(exp_d));
            chk($sformatf("wrap_pvld%0d", i), 32'(rd_pvld), 32'h002);
            cyc();
        end

        // Illegal pop on empty thread 4 and write to out-of-range id.
        drv(1'b0, 4'd4, 7'h00, 4'd4, 1'b1);
        #2;
        $display("pop empty t4 rd_pd=%h err=%0d", rd_pd, err);
        chk("emptypop_err_before", 32'(err),     32'h0);
        chk("emptypop_rdpd",       32'(rd_pd),   32'h0);
        chk("idle_pvld",           32'(rd_pvld), 32'h0);
        cyc();
        drv(1'b0, 4'd4, 7'h00, 4'd4, 1'b0);
        #2;
        chk("emptypop_err", 32'(err),     32'h1);
        chk("emptypop_pvld", 32'(rd_pvld), 32'h0);
        cyc();
        drv(1'b1, 4'd12, 7'h33, 4'd4, 1'b0);
        #2;
        $display("write id 12 prdy=%0d", wr_prdy);
        chk("id12_prdy", 32'(wr_prdy), 32'h0);
        cyc();
        drv(1'b1, 4'd7, 7'h5A, 4'd7, 1'b1);
        #2;
        chk("wrpop_empty_prdy", 32'(wr_prdy), 32'h1);
        chk("wrpop_empty_rdpd", 32'(rd_pd),   32'h0);
        cyc();
        drv(1'b0, 4'd7, 7'h00, 4'd7, 1'b0);
        #2;
        chk("wrpop_empty_head", 32'(rd_pd),   32'h5A);
        chk("wrpop_empty_pvld", 32'(rd_pvld), 32'h080);
        chk("err_sticky",       32'(err),     32'h1);
        cyc();

        // Asynchronous reset with threads 0 and 7 partially full.
        drv(1'b1, 4'd0, 7'h21, 4'd0, 1'b0);
        cyc();
        drv(1'b1, 4'd0, 7'h22, 4'd0, 1'b0);
        cyc();
        drv(1'b1, 4'd7, 7'h23, 4'd0, 1'b0);
        cyc();
        drv(1'b0, 4'd0, 7'h00, 4'd0, 1'b0);
        #2;
        chk("prereset_pvld", 32'(rd_pvld), 32'h081);
        chk("prereset_rdpd", 32'(rd_pd),   32'h21);
        #1;
        rstn = 1'b0;
        #1;
        $display("async reset pvld=%h err=%0d rd_pd=%h", rd_pvld, err, rd_pd);
        chk("async_rst_pvld", 32'(rd_pvld), 32'h0);
        chk("async_rst_err",  32'(err),     32'h0);
        chk("async_rst_rdpd", 32'(rd_pd),   32'h0);
        cyc();
        cyc();
        rstn = 1'b1;
        drv(1'b1, 4'd7, 7'h6C, 4'd7, 1'b0);
        #2;
        chk("postrst_prdy", 32'(wr_prdy), 32'h1);
        chk("postrst_rdpd_empty", 32'(rd_pd), 32'h0);
        cyc();
        drv(1'b0, 4'd7, 7'h00, 4'd7, 1'b0);
        #2;
        $display("post reset t7 head rd_pd=%h pvld=%h", rd_pd, rd_pvld);
        chk("postrst_head", 32'(rd_pd),   32'h6C);
        chk("postrst_pvld", 32'(rd_pvld), 32'h080);
        chk("postrst_err",  32'(err),     32'h0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
